// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response/shared-ALU bundle for alu_arbiter
//
// Signals:
//   reqN_valid/ready, reqN_a/b/shamt/fn : requester N operation handshake
//   rspN_valid/ready, rspN_r/flags       : requester N result handshake, flags = {CF,ZF,VF,SF}
//   alu_a/b/shamt/fn                     : operands driven to the shared ALU
//   alu_r, alu_cf/zf/vf/sf               : shared ALU combinational result
// Modports: slave = arbiter side, master = requester/ALU side.
interface alu_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_fn, req1_fn;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_r, rsp1_r;
    logic [3:0]  rsp0_flags, rsp1_flags;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_fn;
    logic [31:0] alu_r;
    logic        alu_cf, alu_zf, alu_vf, alu_sf;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_shamt, req1_shamt, req0_fn, req1_fn, rsp0_ready, rsp1_ready,
               alu_r, alu_cf, alu_zf, alu_vf, alu_sf,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_r, rsp1_r, rsp0_flags, rsp1_flags,
               alu_a, alu_b, alu_shamt, alu_fn
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_shamt, req1_shamt, req0_fn, req1_fn, rsp0_ready, rsp1_ready,
               alu_r, alu_cf, alu_zf, alu_vf, alu_sf,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_r, rsp1_r, rsp0_flags, rsp1_flags,
               alu_a, alu_b, alu_shamt, alu_fn
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave (requests, responses, shared ALU)
// Parameter RR_EN: 1 = round-robin, 0 = fixed priority (requester 0 highest).
// One transaction in flight: IDLE (grant) -> EXEC (capture ALU) -> RESP (hold until taken).
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nx;
    logic        any_valid, pick, rsp_done;
    logic        grant_q, last_grant_q;
    logic [31:0] a_q, b_q, r_q;
    logic [4:0]  shamt_q;
    logic [3:0]  fn_q, flags_q;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign rsp_done  = (state == RESP) && (grant_q ? bus.rsp1_ready : bus.rsp0_ready);

    // Winner for this cycle; only meaningful when any_valid.
    always_comb begin
        pick = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            pick = RR_EN ? ~last_grant_q : 1'b0;
        else if (!bus.req0_valid)
            pick = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_valid) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ready is qualified by rst_n so it drops immediately while reset is held,
    // even though state is already IDLE and a request may be pending.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        if (state == IDLE && any_valid && rst_n) begin
            bus.req0_ready = ~pick;
            bus.req1_ready = pick;
        end
        if (state == RESP) begin
            bus.rsp0_valid = ~grant_q;
            bus.rsp1_valid = grant_q;
        end
    end

    // Last-grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            shamt_q      <= '0;
            fn_q         <= '0;
            r_q          <= '0;
            flags_q      <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                grant_q      <= pick;
                last_grant_q <= pick;
                a_q          <= pick ? bus.req1_a     : bus.req0_a;
                b_q          <= pick ? bus.req1_b     : bus.req0_b;
                shamt_q      <= pick ? bus.req1_shamt : bus.req0_shamt;
                fn_q         <= pick ? bus.req1_fn    : bus.req0_fn;
            end
            if (state == EXEC) begin
                r_q     <= bus.alu_r;
                flags_q <= {bus.alu_cf, bus.alu_zf, bus.alu_vf, bus.alu_sf};
            end
        end
    end

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_shamt  = shamt_q;
    assign bus.alu_fn     = fn_q;
    assign bus.rsp0_r     = r_q;
    assign bus.rsp1_r     = r_q;
    assign bus.rsp0_flags = flags_q;
    assign bus.rsp1_flags = flags_q;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have, for N in {0,1}, port reqN_valid, input, 1, requester N has an operation pending.
REQ-005 The block SHALL have port reqN_ready, output, 1, operation N accepted this cycle.
REQ-006 The block SHALL have ports reqN_a and reqN_b, input, 32 each, ALU operands A and B.
REQ-007 The block SHALL have ports reqN_shamt (input, 5, shift amount) and reqN_fn (input, 4, ALU function code).
REQ-008 The block SHALL have port rspN_valid, output, 1, result for requester N is available.
REQ-009 The block SHALL have port rspN_ready, input, 1, requester N consumes the result.
REQ-010 The block SHALL have ports rspN_r (output, 32, result) and rspN_flags (output, 4, {CF,ZF,VF,SF}).
REQ-011 The block SHALL have ports alu_a and alu_b, output, 32 each, operands driven to the shared ALU.
REQ-012 The block SHALL have ports alu_shamt (output, 5) and alu_fn (output, 4), driven to the shared ALU.
REQ-013 The block SHALL have ports alu_r (input, 32) and alu_cf, alu_zf, alu_vf, alu_sf (input, 1 each), the shared ALU's combinational outputs.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP; it SHALL issue one transaction at a time.
REQ-015 In IDLE, when any reqN_valid=1, the block SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, latch its a/b/shamt/fn and grant index, and go to EXEC.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP, and SHALL never be 1 for both requesters in the same cycle.
REQ-017 With RR_EN=1 and both valid, the block SHALL grant the requester not granted last; with a single valid, it SHALL grant that one regardless of history.
REQ-018 With RR_EN=0, the block SHALL always grant requester 0 when req0_valid=1.
REQ-019 alu_a, alu_b, alu_shamt and alu_fn SHALL always be driven from the latched registers, which SHALL stay stable from EXEC until the next grant.
REQ-020 In EXEC, the block SHALL capture alu_r and the flags into the result registers at the clock edge and go to RESP.
REQ-021 In RESP, rspG_valid SHALL be 1 for the granted requester G only, and rspG_r/rspG_flags SHALL hold the captured values.
REQ-022 The block SHALL stay in RESP while rspG_ready=0, holding every output stable.
REQ-023 On rspG_valid and rspG_ready both 1, the block SHALL return to IDLE and SHALL NOT accept a new request in that same cycle.
REQ-024 Latency SHALL be fixed: for acceptance at edge T, rsp valid SHALL be asserted in the cycle after edge T+1 (2 edges); peak throughput SHALL be one operation per 3 cycles.
REQ-025 rspN_r and rspN_flags SHALL be driven from the shared result registers for both N; only rspN_valid qualifies them.
REQ-026 Function codes SHALL be passed through unchecked; an undefined fn SHALL return whatever the ALU produces.
REQ-027 If reqN_valid drops before being granted, the block SHALL record no transaction for N.

Reset
REQ-028 While rst_n=0, the block SHALL immediately, without waiting for clk, force state=IDLE, reqN_ready=0, rspN_valid=0, all latched operand/fn/result/flag registers to 0, and last-grant=1, so that requester 0 wins the first tie.
REQ-029 If reset asserts in EXEC or RESP, the in-flight transaction SHALL be discarded and no response SHALL be produced after reset releases.

Verification
REQ-030 The bench SHALL drive req0 with ADD fn=0000, a=5, b=7 -> req0_ready=1 in the same cycle, then rsp0_valid=1 two edges later with rsp0_r=12 and flags=0000.
REQ-031 The bench SHALL drive req1 with SUB fn=0001, a=3, b=3 -> rsp1_r=0 and flags {CF,ZF,VF,SF}=1100; rsp0_valid SHALL stay 0 throughout.
REQ-032 The bench SHALL assert req0_valid and req1_valid together after reset, both held, with RR_EN=1 -> grants SHALL go 0,1,0,1 across four transactions.
REQ-033 With RR_EN=0, the bench SHALL hold both requests valid -> requester 0 SHALL be granted every transaction and req1_ready SHALL stay 0.
REQ-034 The bench SHALL hold rsp0_ready=0 for 4 cycles in RESP with req1_valid=1 -> rsp0_r SHALL stay stable and req1_ready=0 throughout; after rsp0_ready=1, req1 SHALL be granted on the following IDLE cycle.
REQ-035 The bench SHALL pulse rst_n=0 during EXEC -> all outputs SHALL be 0 asynchronously, and no rspN_valid SHALL appear after release.
